// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO controllers and their write-side arbiter.
package afifo_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/afifo_wr_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at/after ptr, wrapping.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] kidx;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    kidx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      kidx = IDW'((32'(ptr) + i) % NREQ);
      if (!any && req[kidx]) begin
        any         = 1'b1;
        idx         = kidx;
        grant[kidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Packet-aware round-robin arbiter sharing the async FIFO write port among NREQ requesters.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter  int unsigned DSIZE     = 8,
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ-1:0]         i_req_last,
  input  logic [NREQ*DSIZE-1:0]   i_req_data,
  output logic [NREQ-1:0]         o_req_ready,
  output logic                    o_wr,
  output logic [DSIZE-1:0]        o_wdata,
  output logic [IDW-1:0]          o_wsrc,
  input  logic                    i_wfull,
  output logic [NREQ-1:0]         o_grant,
  output logic                    o_busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  arb_state_t      state;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  wsrc;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   count;

  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  logic [DSIZE-1:0] sel_data;
  logic             sel_valid;
  logic             sel_last;
  logic             accept;
  logic             burst_end;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Zero-latency beat path: the granted requester's lane is muxed straight to the FIFO.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (wsrc == IDW'(k)) begin
        sel_data  = i_req_data[k*DSIZE +: DSIZE];
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
      end
    end
    accept    = (state == ARB_BURST) && sel_valid && !i_wfull;
    burst_end = accept && (sel_last || (count == LAST_CNT));
  end

  assign o_wr        = accept;
  assign o_req_ready = accept ? grant : '0;
  assign o_wdata     = (state == ARB_BURST) ? sel_data : '0;
  assign o_wsrc      = wsrc;
  assign o_grant     = grant;
  assign o_busy      = (state == ARB_BURST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
      wsrc  <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant <= pick_oh;
            wsrc  <= pick_idx;
            count <= '0;
            state <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (burst_end) begin
            state <= ARB_IDLE;
            grant <= '0;
            ptr   <= IDW'(rr_next(32'(wsrc), NREQ));
            count <= '0;
          end else if (accept) begin
            count <= count + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_no_wr_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_wr && i_wfull));
  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_ready));
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count < CW'(MAX_BURST));

endmodule
